lane_unstriper: RTL and testbench
=================================

# lane_unstriper

Receive-side lane reassembly block for the PCI PHY lane path. It takes the single byte-wide stream produced by the 4:1 lane striping mux and rebuilds the four parallel lanes, `dataOut0..3` with per-lane valids, one group per four byte slots. Alignment comes from a start-of-group marker, and misalignment is detected and recovered from. It sits after the striping mux and presents lanes at the lane-clock boundary to downstream logic.

## Interface
- `DATA_W`, 8, byte width of the stream and of each lane.
- `clk_1`  input  1  byte-rate clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = in reset).
- `dataIn`  input  DATA_W  striped byte for the current slot.
- `validIn`  input  1  valid bit of the lane carried in the current slot.
- `syncIn`  input  1  marks the current slot as lane 0 of a new group.
- `dataOut0..dataOut3`  output  DATA_W each  reassembled lane bytes.
- `validOut0..validOut3`  output  1 each  reassembled lane valids.
- `groupStrobe`  output  1  one-cycle pulse when a new group is presented.
- `alignErr`  output  1  one-cycle pulse on an alignment fault.
- `errCount`  output  8  saturating alignment-fault count; present only with `LANE_UNSTRIPER_ERRCNT_EN`.

## Operation
- The state machine has two states, UNSYNC and COLLECT. A 2-bit slot counter `slot` holds 0..3.
- **UNSYNC:**
  - `syncIn=0`: the slot is ignored.
  - `syncIn=1`: store `dataIn`/`validIn` as lane 0, set `slot<=1`, go to COLLECT.
- **COLLECT, `slot` = 1..3:**
  - `syncIn=0`: store the byte and valid into staging lane `slot`, then `slot<=slot+1`.
  - `syncIn=1`: misaligned marker. Pulse `alignErr` and discard the staged partial group. Store the current byte as the new lane 0 and set `slot<=1`.
- **COLLECT, `slot` wraps 3→0:**
  - Staging lanes 0..2 plus the slot-3 byte are copied to `dataOut0..3`/`validOut0..3` on the same edge. `groupStrobe` is pulsed.
  - The next slot must carry `syncIn=1`. If it does, it becomes lane 0 of the following group and the FSM stays in COLLECT.
  - If it does not, pulse `alignErr`, drop the byte, and go to UNSYNC.
- A lane with `validIn=0` is still a slot. It occupies its position, and its `dataOut` byte is taken as received.
- Outputs hold their last group until the next completed group. Partial groups never reach the outputs.

## Timing
- **Reset (`reset=0`):** effective immediately, independent of `clk_1`.
  - State UNSYNC, `slot=0`, staging registers 0.
  - All `dataOut*` = 0, all `validOut*` = 0, `groupStrobe=0`, `alignErr=0`, `errCount=0`.
- **Reset release:** the first edge after release can accept `syncIn`.
- **Reset mid-group:** the staged partial group is lost. The outputs return to 0 and do not keep the previous group.
- **Latency:** if the lane-0 byte is sampled at edge N, the outputs and `groupStrobe` are valid after edge N+3. The strobe is high for exactly the cycle following edge N+3.
- **Back-to-back groups:** one group every 4 cycles, with no bubble required.
- **`syncIn` coincident with the wrap:** this cannot occur. Slot 3 with `syncIn=1` is handled as a misaligned marker, so the group is not presented and no `groupStrobe` is issued.
- **`alignErr` and `groupStrobe`:** never high in the same cycle.

## Configuration
- `LANE_UNSTRIPER_ERRCNT_EN` defined:
  - The `errCount` port and its 8-bit register exist.
  - The counter increments on every `alignErr` pulse and saturates at 255.
  - It is cleared only by reset.
- Not defined:
  - The port and the register are absent.
  - `alignErr` behaviour is unchanged.

## Test plan
- **Reset values:** hold `reset=0` for 3 cycles, then release. Required: all outputs 0 and no strobe until the first `syncIn`.
- **Single group:** `syncIn` on FF, then EE, DD, CC, all valid. Required: `dataOut0..3`=FF,EE,DD,CC, `validOut`=1111, and `groupStrobe` for one cycle 3 edges after the FF slot.
- **Back-to-back groups with a partial valid:**
  - Send BB,AA,99,88, then 00,00,77,00 with valids 0,0,1,0.
  - Required: two strobes 4 cycles apart. The second group reads 00,00,77,00 with `validOut`=0010.
- **Misaligned marker:** `syncIn` at slot 2. Required: `alignErr` pulse, no strobe for the partial group, and a correct group completes 4 slots after the new marker.
- **Missing marker after a group:** no `syncIn` on the slot after a wrap. Required: `alignErr`, UNSYNC, the previous outputs held, and later slots ignored until `syncIn`.
- **Error counter (with `LANE_UNSTRIPER_ERRCNT_EN`):** inject 260 alignment faults, then assert reset mid-group. Required: `errCount` reads 255 before reset, and `errCount` and all outputs read 0 during reset.

Source files
------------

// File: rtl/lane_unstriper.sv
// Rebuilds four parallel lanes from a byte-wide striped stream, aligned on syncIn markers.
// Optional saturating alignment-fault counter on errCount, enabled by LANE_UNSTRIPER_ERRCNT_EN.
module lane_unstriper #(
    parameter int DATA_W = 8
) (
    input  logic              clk_1,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              validIn,
    input  logic              syncIn,
    output logic [DATA_W-1:0] dataOut0,
    output logic [DATA_W-1:0] dataOut1,
    output logic [DATA_W-1:0] dataOut2,
    output logic [DATA_W-1:0] dataOut3,
    output logic              validOut0,
    output logic              validOut1,
    output logic              validOut2,
    output logic              validOut3,
`ifdef LANE_UNSTRIPER_ERRCNT_EN
    output logic [7:0]        errCount,
`endif
    output logic              groupStrobe,
    output logic              alignErr
);

    typedef enum logic {
        UNSYNC  = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               slot_q, slot_d;
    logic [2:0][DATA_W-1:0]   stage_data_q, stage_data_d;
    logic [2:0]               stage_valid_q, stage_valid_d;
    logic [3:0][DATA_W-1:0]   out_data_q, out_data_d;
    logic [3:0]               out_valid_q, out_valid_d;
    logic                     strobe_q, strobe_d;
    logic                     err_q, err_d;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        stage_data_d  = stage_data_q;
        stage_valid_d = stage_valid_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        strobe_d      = 1'b0;
        err_d         = 1'b0;

        unique case (state_q)
            UNSYNC: begin
                if (syncIn) begin
                    stage_data_d[0]  = dataIn;
                    stage_valid_d[0] = validIn;
                    slot_d           = 2'd1;
                    state_d          = COLLECT;
                end
            end

            COLLECT: begin
                if (slot_q == 2'd0) begin
                    // Slot right after a wrap must open the next group.
                    if (syncIn) begin
                        stage_data_d[0]  = dataIn;
                        stage_valid_d[0] = validIn;
                        slot_d           = 2'd1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = UNSYNC;
                    end
                end else if (syncIn) begin
                    // Misaligned marker: drop the partial group and restart from this byte.
                    err_d            = 1'b1;
                    stage_data_d     = '0;
                    stage_valid_d    = '0;
                    stage_data_d[0]  = dataIn;
                    stage_valid_d[0] = validIn;
                    slot_d           = 2'd1;
                end else if (slot_q == 2'd3) begin
                    out_data_d  = {dataIn, stage_data_q[2], stage_data_q[1], stage_data_q[0]};
                    out_valid_d = {validIn, stage_valid_q[2], stage_valid_q[1], stage_valid_q[0]};
                    strobe_d    = 1'b1;
                    slot_d      = 2'd0;
                end else begin
                    if (slot_q == 2'd1) begin
                        stage_data_d[1]  = dataIn;
                        stage_valid_d[1] = validIn;
                    end else begin
                        stage_data_d[2]  = dataIn;
                        stage_valid_d[2] = validIn;
                    end
                    slot_d = slot_q + 2'd1;
                end
            end

            default: state_d = UNSYNC;
        endcase
    end

    // NOTE: staging and output registers are reset too, so a reset mid-group leaves nothing stale visible.
    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            state_q       <= UNSYNC;
            slot_q        <= 2'd0;
            stage_data_q  <= '0;
            stage_valid_q <= '0;
            out_data_q    <= '0;
            out_valid_q   <= '0;
            strobe_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q       <= state_d;
            slot_q        <= slot_d;
            stage_data_q  <= stage_data_d;
            stage_valid_q <= stage_valid_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            strobe_q      <= strobe_d;
            err_q         <= err_d;
        end
    end

`ifdef LANE_UNSTRIPER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_1 or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign errCount = err_cnt_q;
`endif

    assign dataOut0    = out_data_q[0];
    assign dataOut1    = out_data_q[1];
    assign dataOut2    = out_data_q[2];
    assign dataOut3    = out_data_q[3];
    assign validOut0   = out_valid_q[0];
    assign validOut1   = out_valid_q[1];
    assign validOut2   = out_valid_q[2];
    assign validOut3   = out_valid_q[3];
    assign groupStrobe = strobe_q;
    assign alignErr    = err_q;

endmodule

// File: tb/tb_lane_unstriper.sv
// Directed bench for lane_unstriper: inputs driven on the falling edge, outputs sampled 1 ns after the rising edge.
module tb_lane_unstriper;

    logic       clk_1 = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       validIn = 1'b0;
    logic       syncIn = 1'b0;
    logic [7:0] dataOut0, dataOut1, dataOut2, dataOut3;
    logic       validOut0, validOut1, validOut2, validOut3;
    logic       groupStrobe, alignErr;
`ifdef LANE_UNSTRIPER_ERRCNT_EN
    logic [7:0] errCount;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_1 = ~clk_1;

    lane_unstriper #(.DATA_W(8)) dut (
        .clk_1      (clk_1),
        .reset      (reset),
        .dataIn     (dataIn),
        .validIn    (validIn),
        .syncIn     (syncIn),
        .dataOut0   (dataOut0),
        .dataOut1   (dataOut1),
        .dataOut2   (dataOut2),
        .dataOut3   (dataOut3),
        .validOut0  (validOut0),
        .validOut1  (validOut1),
        .validOut2  (validOut2),
        .validOut3  (validOut3),
`ifdef LANE_UNSTRIPER_ERRCNT_EN
        .errCount   (errCount),
`endif
        .groupStrobe(groupStrobe),
        .alignErr   (alignErr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lanes are packed lane 0 first so the constants read like the lane order.
    task automatic check_outs(input string tag, input logic [31:0] exp_data, input logic [3:0] exp_valid,
                              input logic exp_strobe, input logic exp_err);
        check({tag, ".data"},   {dataOut0, dataOut1, dataOut2, dataOut3}, exp_data);
        check({tag, ".valid"},  {28'd0, validOut0, validOut1, validOut2, validOut3}, {28'd0, exp_valid});
        check({tag, ".strobe"}, {31'd0, groupStrobe}, {31'd0, exp_strobe});
        check({tag, ".err"},    {31'd0, alignErr}, {31'd0, exp_err});
    endtask

    task automatic send(input logic [7:0] d, input logic v, input logic s);
        @(negedge clk_1);
        dataIn  = d;
        validIn = v;
        syncIn  = s;
        @(posedge clk_1);
        #1;
    endtask

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(posedge clk_1);
        #1;
        check_outs("reset", 32'h0, 4'b0000, 1'b0, 1'b0);
`ifdef LANE_UNSTRIPER_ERRCNT_EN
        check("reset.errcnt", {24'd0, errCount}, 32'd0);
`endif
        @(negedge clk_1);
        reset = 1'b1;

        // Unsynced slots are ignored
        send(8'h5A, 1'b1, 1'b0);
        send(8'h5B, 1'b1, 1'b0);
        send(8'h5C, 1'b1, 1'b0);
        send(8'h5D, 1'b1, 1'b0);
        check_outs("unsync_idle", 32'h0, 4'b0000, 1'b0, 1'b0);

        // Single group
        send(8'hFF, 1'b1, 1'b1);
        check_outs("g1.slot0", 32'h0, 4'b0000, 1'b0, 1'b0);
        send(8'hEE, 1'b1, 1'b0);
        send(8'hDD, 1'b1, 1'b0);
        check_outs("g1.slot2", 32'h0, 4'b0000, 1'b0, 1'b0);
        send(8'hCC, 1'b1, 1'b0);
        check_outs("g1.done", 32'hFFEEDDCC, 4'b1111, 1'b1, 1'b0);

        // Back-to-back groups, second with a partial valid
        send(8'hBB, 1'b1, 1'b1);
        check_outs("g2.slot0", 32'hFFEEDDCC, 4'b1111, 1'b0, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        send(8'h99, 1'b1, 1'b0);
        send(8'h88, 1'b1, 1'b0);
        check_outs("g2.done", 32'hBBAA9988, 4'b1111, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b1);
        check_outs("g3.slot0", 32'hBBAA9988, 4'b1111, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'h77, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        check_outs("g3.done", 32'h00007700, 4'b0010, 1'b1, 1'b0);

        // Misaligned marker at slot 2
        send(8'h11, 1'b1, 1'b1);
        send(8'h22, 1'b1, 1'b0);
        send(8'h33, 1'b1, 1'b1);
        check_outs("mis.err", 32'h00007700, 4'b0010, 1'b0, 1'b1);
`ifdef LANE_UNSTRIPER_ERRCNT_EN
        check("mis.errcnt", {24'd0, errCount}, 32'd1);
`endif
        send(8'h44, 1'b1, 1'b0);
        check_outs("mis.slot1", 32'h00007700, 4'b0010, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        send(8'h66, 1'b1, 1'b0);
        check_outs("mis.done", 32'h33445566, 4'b1101, 1'b1, 1'b0);

        // Missing marker after a wrap
        send(8'h12, 1'b1, 1'b0);
        check_outs("miss.err", 32'h33445566, 4'b1101, 1'b0, 1'b1);
        send(8'h13, 1'b1, 1'b0);
        send(8'h14, 1'b1, 1'b0);
        send(8'h15, 1'b1, 1'b0);
        send(8'h16, 1'b1, 1'b0);
        check_outs("miss.ignored", 32'h33445566, 4'b1101, 1'b0, 1'b0);

        // Marker on slot 3 is a misaligned marker, not a wrap
        send(8'hA1, 1'b1, 1'b1);
        send(8'hA2, 1'b1, 1'b0);
        send(8'hA3, 1'b1, 1'b0);
        send(8'hA4, 1'b1, 1'b1);
        check_outs("slot3sync.err", 32'h33445566, 4'b1101, 1'b0, 1'b1);
        send(8'hB2, 1'b1, 1'b0);
        send(8'hB3, 1'b1, 1'b0);
        send(8'hB4, 1'b0, 1'b0);
        check_outs("slot3sync.done", 32'hA4B2B3B4, 4'b1110, 1'b1, 1'b0);
`ifdef LANE_UNSTRIPER_ERRCNT_EN
        check("slot3sync.errcnt", {24'd0, errCount}, 32'd3);

        // 260 more faults: open a group, then repeated markers at slot 1
        send(8'hE0, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) begin
            send(8'hE1, 1'b1, 1'b1);
        end
        check("sat.errcnt", {24'd0, errCount}, 32'd255);
`endif

        // Reset mid-group
        send(8'hC1, 1'b1, 1'b1);
        send(8'hC2, 1'b1, 1'b0);
        @(negedge clk_1);
        reset = 1'b0;
        #1;
        check_outs("midreset", 32'h0, 4'b0000, 1'b0, 1'b0);
`ifdef LANE_UNSTRIPER_ERRCNT_EN
        check("midreset.errcnt", {24'd0, errCount}, 32'd0);
`endif
        @(negedge clk_1);
        reset = 1'b1;

        // Partial group is gone: slots without a marker complete nothing
        send(8'hC3, 1'b1, 1'b0);
        send(8'hC4, 1'b1, 1'b0);
        check_outs("postreset.idle", 32'h0, 4'b0000, 1'b0, 1'b0);
        send(8'hD1, 1'b1, 1'b1);
        send(8'hD2, 1'b1, 1'b0);
        send(8'hD3, 1'b1, 1'b0);
        send(8'hD4, 1'b1, 1'b0);
        check_outs("postreset.group", 32'hD1D2D3D4, 4'b1111, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
